// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, divider bundle and constants for the PLL reconfiguration sequencer.
// Types only: no logic, no latency, no flow control.
package pll_ctrl_pkg;

    localparam int         DIV_W    = 6;
    localparam logic [4:0] GATE_ALL = 5'h1F;

    typedef enum logic [2:0] {
        ST_PWD,
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_FAIL
    } pll_state_t;

    typedef struct packed {
        logic [DIV_W-1:0] idiv;
        logic [DIV_W-1:0] fdiv;
        logic [DIV_W-1:0] odiv;
        logic [DIV_W-1:0] o2div;
        logic [DIV_W-1:0] o3div;
        logic [DIV_W-1:0] o4div;
    } div_cfg_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counters only ever hold max_val-1, so $clog2(max_val) bits suffice.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

    function automatic logic cfg_valid(input div_cfg_t c);
        return (c.idiv != '0) && (c.fdiv != '0) && (c.odiv != '0) &&
               (c.o2div != '0) && (c.o3div != '0) && (c.o4div != '0);
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop LOCK synchronizer plus consecutive-high counter; lock_stable is combinational on the counter.
// Latency: raw LOCK reaches lock_loss after 2 cycles; no backpressure.
module pll_lock_filter
    import pll_ctrl_pkg::*;
#(
    parameter int LOCK_STABLE = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_raw,
    input  logic count_en,
    output logic lock_stable,
    output logic lock_loss
);

    localparam int            SW          = cnt_width(LOCK_STABLE);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);

    logic          sync_meta;
    logic          sync_q;
    logic [SW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync_q     <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_meta <= lock_raw;
            sync_q    <= sync_meta;
            if (!count_en || !sync_q) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_LAST) begin
                stable_cnt <= stable_cnt + SW'(1);
            end
        end
    end

    // The cycle that sees the LOCK_STABLE-th consecutive high sample declares lock.
    assign lock_stable = sync_q && (stable_cnt == STABLE_LAST);
    assign lock_loss   = !sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL sequencer: PWD -> RST_PLL -> WAIT_LOCK with retry/FAIL and automatic relock after lock loss.
// Outputs registered from next state (1 cycle); REQ_READY only in LOCKED/FAIL, else requests stall.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int DEF_IDIV     = 1,
    parameter int DEF_FDIV     = 1,
    parameter int DEF_ODIV     = 2,
    parameter int DEF_O2DIV    = 2,
    parameter int DEF_O3DIV    = 2,
    parameter int DEF_O4DIV    = 2,
    parameter int PWD_CYCLES   = 16,
    parameter int RST_CYCLES   = 32,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [DIV_W-1:0] REQ_IDIV,
    input  logic [DIV_W-1:0] REQ_FDIV,
    input  logic [DIV_W-1:0] REQ_ODIV,
    input  logic [DIV_W-1:0] REQ_O2DIV,
    input  logic [DIV_W-1:0] REQ_O3DIV,
    input  logic [DIV_W-1:0] REQ_O4DIV,
    output logic             REQ_ERR,
    input  logic             PLL_LOCK,
    output logic             PLL_PWD,
    output logic             PLL_RST,
    output logic             RESET_IDIV,
    output logic             RESET_ODIV,
    output logic [DIV_W-1:0] DYN_IDIV,
    output logic [DIV_W-1:0] DYN_FDIV,
    output logic [DIV_W-1:0] CIM_DYNODIV,
    output logic [DIV_W-1:0] CIM_DYNO2DIV,
    output logic [DIV_W-1:0] CIM_DYNO3DIV,
    output logic [DIV_W-1:0] CIM_DYNO4DIV,
    output logic [4:0]       GATEO,
    output logic             LOCKED,
    output logic             FAIL,
    output logic [1:0]       RETRY_CNT,
    output logic [7:0]       LOSS_CNT
);

    localparam int            CW        = cnt_width(max3(PWD_CYCLES, RST_CYCLES, LOCK_TIMEOUT));
    localparam logic [CW-1:0] PWD_LAST  = CW'(PWD_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
    localparam div_cfg_t      DEF_CFG   = '{
        idiv:  DIV_W'(DEF_IDIV),  fdiv:  DIV_W'(DEF_FDIV),
        odiv:  DIV_W'(DEF_ODIV),  o2div: DIV_W'(DEF_O2DIV),
        o3div: DIV_W'(DEF_O3DIV), o4div: DIV_W'(DEF_O4DIV)
    };

    pll_state_t    state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [1:0]    retry_nxt;
    div_cfg_t      div_q;
    div_cfg_t      req_cfg;
    logic          accept;
    logic          reject;
    logic          loss_inc;
    logic          lock_stable;
    logic          lock_loss;

    assign req_cfg = {REQ_IDIV, REQ_FDIV, REQ_ODIV, REQ_O2DIV, REQ_O3DIV, REQ_O4DIV};

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk         (CLK),
        .rst         (RST),
        .lock_raw    (PLL_LOCK),
        .count_en    (state_q == ST_WAIT_LOCK),
        .lock_stable (lock_stable),
        .lock_loss   (lock_loss)
    );

    always_comb begin
        accept    = REQ_VALID && REQ_READY && cfg_valid(req_cfg);
        reject    = REQ_VALID && REQ_READY && !cfg_valid(req_cfg);
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        retry_nxt = RETRY_CNT;
        loss_inc  = 1'b0;

        case (state_q)
            ST_PWD: begin
                if (cnt_q == PWD_LAST) begin
                    state_nxt = ST_RST_PLL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            ST_RST_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // A lock that completes on the timeout cycle still counts as locked.
                if (lock_stable) begin
                    state_nxt = ST_LOCKED;
                    cnt_nxt   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_nxt = '0;
                    if (RETRY_CNT < RETRY_MAX) begin
                        retry_nxt = RETRY_CNT + 2'd1;
                        state_nxt = ST_RST_PLL;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            ST_LOCKED: begin
                if (lock_loss) begin
                    loss_inc  = 1'b1;
                    state_nxt = ST_RST_PLL;
                    cnt_nxt   = '0;
                    retry_nxt = 2'd0;
                end
            end
            ST_FAIL: begin
                state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt = ST_RST_PLL;
                cnt_nxt   = '0;
            end
        endcase

        // A new request overrides a simultaneous lock loss; the loss is still counted.
        if (accept) begin
            state_nxt = ST_PWD;
            cnt_nxt   = '0;
            retry_nxt = 2'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_RST_PLL;
            cnt_q     <= '0;
            RETRY_CNT <= 2'd0;
            LOSS_CNT  <= 8'd0;
            div_q     <= DEF_CFG;
            REQ_READY <= 1'b0;
            REQ_ERR   <= 1'b0;
            PLL_PWD   <= 1'b0;
            PLL_RST   <= 1'b1;
            GATEO     <= GATE_ALL;
            LOCKED    <= 1'b0;
            FAIL      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            RETRY_CNT <= retry_nxt;
            if (loss_inc && (LOSS_CNT != 8'hFF)) begin
                LOSS_CNT <= LOSS_CNT + 8'd1;
            end
            if (accept) begin
                div_q <= req_cfg;
            end
            REQ_ERR   <= reject;
            REQ_READY <= (state_nxt == ST_LOCKED) || (state_nxt == ST_FAIL);
            PLL_PWD   <= (state_nxt == ST_PWD);
            PLL_RST   <= (state_nxt == ST_RST_PLL) || (state_nxt == ST_FAIL);
            GATEO     <= (state_nxt == ST_LOCKED) ? 5'h00 : GATE_ALL;
            LOCKED    <= (state_nxt == ST_LOCKED);
            FAIL      <= (state_nxt == ST_FAIL);
        end
    end

    assign RESET_IDIV   = PLL_RST;
    assign RESET_ODIV   = PLL_RST;
    assign DYN_IDIV     = div_q.idiv;
    assign DYN_FDIV     = div_q.fdiv;
    assign CIM_DYNODIV  = div_q.odiv;
    assign CIM_DYNO2DIV = div_q.o2div;
    assign CIM_DYNO3DIV = div_q.o3div;
    assign CIM_DYNO4DIV = div_q.o4div;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: request table, lock/loss/timeout sequences, random drops.
// Expected values come from the bench's own divider/loss bookkeeping and fixed sequence lengths.
module tb_pll_reconfig_ctrl;

    localparam int PWD_C   = 16;
    localparam int RST_C   = 32;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 50;
    localparam int RETRIES = 3;

    typedef struct packed {
        logic [5:0] idiv;
        logic [5:0] fdiv;
        logic [5:0] odiv;
        logic [5:0] o2div;
        logic [5:0] o3div;
        logic [5:0] o4div;
    } divs_t;

    typedef struct {
        divs_t d;
        logic  exp_err;
    } vec_t;

    localparam divs_t DEF_D = {6'd1, 6'd1, 6'd2, 6'd2, 6'd2, 6'd2};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       PLL_LOCK = 1'b0;
    divs_t      req_d = '0;
    logic       REQ_READY, REQ_ERR, PLL_PWD, PLL_RST, RESET_IDIV, RESET_ODIV;
    logic [5:0] DYN_IDIV, DYN_FDIV, CIM_DYNODIV, CIM_DYNO2DIV, CIM_DYNO3DIV, CIM_DYNO4DIV;
    logic [4:0] GATEO;
    logic       LOCKED, FAIL;
    logic [1:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;
    divs_t      cur_d;

    int checks = 0;
    int errors = 0;

    assign cur_d = {DYN_IDIV, DYN_FDIV, CIM_DYNODIV, CIM_DYNO2DIV, CIM_DYNO3DIV, CIM_DYNO4DIV};

    always #5 CLK = ~CLK;

    pll_reconfig_ctrl #(
        .DEF_IDIV (1), .DEF_FDIV (1), .DEF_ODIV (2), .DEF_O2DIV (2), .DEF_O3DIV (2), .DEF_O4DIV (2),
        .PWD_CYCLES (PWD_C), .RST_CYCLES (RST_C), .LOCK_STABLE (STABLE),
        .LOCK_TIMEOUT (TIMEOUT), .MAX_RETRY (RETRIES)
    ) dut (
        .CLK (CLK), .RST (RST),
        .REQ_VALID (REQ_VALID), .REQ_READY (REQ_READY),
        .REQ_IDIV (req_d.idiv), .REQ_FDIV (req_d.fdiv), .REQ_ODIV (req_d.odiv),
        .REQ_O2DIV (req_d.o2div), .REQ_O3DIV (req_d.o3div), .REQ_O4DIV (req_d.o4div),
        .REQ_ERR (REQ_ERR), .PLL_LOCK (PLL_LOCK),
        .PLL_PWD (PLL_PWD), .PLL_RST (PLL_RST), .RESET_IDIV (RESET_IDIV), .RESET_ODIV (RESET_ODIV),
        .DYN_IDIV (DYN_IDIV), .DYN_FDIV (DYN_FDIV), .CIM_DYNODIV (CIM_DYNODIV),
        .CIM_DYNO2DIV (CIM_DYNO2DIV), .CIM_DYNO3DIV (CIM_DYNO3DIV), .CIM_DYNO4DIV (CIM_DYNO4DIV),
        .GATEO (GATEO), .LOCKED (LOCKED), .FAIL (FAIL),
        .RETRY_CNT (RETRY_CNT), .LOSS_CNT (LOSS_CNT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic fields_ok(input divs_t d);
        for (int f = 0; f < 6; f++) begin
            if (d[f*6 +: 6] == 6'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  REQ_READY,  0);
        check({tag, "_err"},    REQ_ERR,    0);
        check({tag, "_pwd"},    PLL_PWD,    0);
        check({tag, "_pllrst"}, PLL_RST,    1);
        check({tag, "_rsti"},   RESET_IDIV, 1);
        check({tag, "_rsto"},   RESET_ODIV, 1);
        check({tag, "_divs"},   cur_d,      DEF_D);
        check({tag, "_gate"},   GATEO,      5'h1F);
        check({tag, "_locked"}, LOCKED,     0);
        check({tag, "_fail"},   FAIL,       0);
        check({tag, "_retry"},  RETRY_CNT,  0);
        check({tag, "_loss"},   LOSS_CNT,   0);
    endtask

    task automatic measure_pwd(output int n);
        n = 0;
        while (PLL_PWD === 1'b1 && n < 1000) begin n++; tick(); end
    endtask

    task automatic measure_rst(output int n);
        n = 0;
        while (PLL_RST === 1'b1 && n < 1000) begin n++; tick(); end
    endtask

    task automatic wait_locked(input string name);
        int n;
        n = 0;
        while (LOCKED !== 1'b1 && n < 400) begin tick(); n++; end
        check(name, LOCKED, 1);
    endtask

    // Called right after an edge: LOCK rises now, LOCKED must follow 2 sync + STABLE edges later.
    task automatic raise_and_time(input string name);
        int n;
        PLL_LOCK = 1'b1;
        n = 0;
        while (LOCKED !== 1'b1 && n < 100) begin tick(); n++; end
        check(name, n, STABLE + 2);
    endtask

    task automatic send_req(input divs_t d);
        int n;
        n = 0;
        while (REQ_READY !== 1'b1 && n < 400) begin tick(); n++; end
        check("req_ready_wait", REQ_READY, 1);
        req_d = d;
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  vt [6];
        divs_t exp_d;
        divs_t rd;
        int    exp_loss;
        int    n;
        int    rises;
        logic  prev;

        vt[0].d = {6'd2,  6'd20, 6'd4,  6'd2,  6'd2,  6'd2};  vt[0].exp_err = 1'b0;
        vt[1].d = {6'd2,  6'd20, 6'd4,  6'd2,  6'd0,  6'd2};  vt[1].exp_err = 1'b1;
        vt[2].d = {6'd0,  6'd5,  6'd5,  6'd5,  6'd5,  6'd5};  vt[2].exp_err = 1'b1;
        vt[3].d = {6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63}; vt[3].exp_err = 1'b0;
        vt[4].d = {6'd5,  6'd10, 6'd2,  6'd3,  6'd4,  6'd0};  vt[4].exp_err = 1'b1;
        vt[5].d = {6'd1,  6'd1,  6'd1,  6'd1,  6'd1,  6'd1};  vt[5].exp_err = 1'b0;

        // Reset and first bring-up.
        RST = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        RST = 1'b0;
        measure_rst(n);
        check("boot_rst_len", n, RST_C);
        check("boot_ready_low", REQ_READY, 0);
        repeat (20) tick();
        raise_and_time("boot_lock_latency");
        check("boot_divs", cur_d, DEF_D);
        check("boot_gate", GATEO, 0);
        check("boot_ready", REQ_READY, 1);

        // Request table.
        exp_d = DEF_D;
        for (int i = 0; i < 6; i++) begin
            send_req(vt[i].d);
            check($sformatf("vec%0d_err", i), REQ_ERR, vt[i].exp_err);
            if (!vt[i].exp_err) exp_d = vt[i].d;
            check($sformatf("vec%0d_divs", i), cur_d, exp_d);
            if (vt[i].exp_err) begin
                check($sformatf("vec%0d_ready_kept", i), REQ_READY, 1);
                tick();
                check($sformatf("vec%0d_err_pulse", i), REQ_ERR, 0);
                check($sformatf("vec%0d_still_locked", i), LOCKED, 1);
            end else begin
                PLL_LOCK = 1'b0;
                check($sformatf("vec%0d_gate", i), GATEO, 5'h1F);
                check($sformatf("vec%0d_ready_low", i), REQ_READY, 0);
                measure_pwd(n);
                check($sformatf("vec%0d_pwd_len", i), n, PWD_C);
                measure_rst(n);
                check($sformatf("vec%0d_rst_len", i), n, RST_C);
                raise_and_time($sformatf("vec%0d_relock", i));
                check($sformatf("vec%0d_gate_open", i), GATEO, 0);
            end
        end

        // One-cycle lock drop while locked.
        exp_loss = 0;
        PLL_LOCK = 1'b0; tick(); PLL_LOCK = 1'b1; tick();
        check("loss_locked_e2", LOCKED, 1);
        tick();
        exp_loss++;
        check("loss_locked_e3", LOCKED, 0);
        check("loss_gate", GATEO, 5'h1F);
        check("loss_cnt", LOSS_CNT, exp_loss);
        check("loss_pllrst", PLL_RST, 1);
        check("loss_retry", RETRY_CNT, 0);
        wait_locked("loss_relock");
        check("loss_divs", cur_d, exp_d);

        // Lock loss and accepted request on the same edge.
        PLL_LOCK = 1'b0; tick(); PLL_LOCK = 1'b1; tick();
        rd = {6'd9, 6'd18, 6'd3, 6'd4, 6'd5, 6'd6};
        req_d = rd;
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        exp_loss++;
        exp_d = rd;
        check("race_pwd", PLL_PWD, 1);
        check("race_loss", LOSS_CNT, exp_loss);
        check("race_divs", cur_d, exp_d);
        wait_locked("race_relock");

        // Random requests and 300 lock drops against the bookkeeping model.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int f = 0; f < 6; f++)
                    rd[f*6 +: 6] = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                send_req(rd);
                check("rnd_err", REQ_ERR, !fields_ok(rd));
                if (fields_ok(rd)) begin
                    exp_d = rd;
                    wait_locked("rnd_req_relock");
                end
                check("rnd_divs", cur_d, exp_d);
            end
            repeat ($urandom_range(0, 5)) tick();
            PLL_LOCK = 1'b0; tick(); PLL_LOCK = 1'b1; tick(); tick();
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            check("rnd_drop", LOCKED, 0);
            check("rnd_loss_cnt", LOSS_CNT, exp_loss);
            wait_locked("rnd_relock");
        end
        check("loss_saturated", LOSS_CNT, 255);

        // LOCK never returns: retries then FAIL.
        rd = {6'd4, 6'd8, 6'd2, 6'd3, 6'd5, 6'd6};
        send_req(rd);
        exp_d = rd;
        PLL_LOCK = 1'b0;
        rises = 0;
        prev = PLL_RST;
        n = 0;
        while (FAIL !== 1'b1 && n < 2000) begin
            tick();
            n++;
            if (PLL_RST && !prev && !FAIL) rises++;
            prev = PLL_RST;
        end
        check("fail_reached", FAIL, 1);
        check("fail_cycles", n, PWD_C + (RETRIES + 1) * (RST_C + TIMEOUT));
        check("fail_rst_entries", rises, RETRIES + 1);
        check("fail_retry", RETRY_CNT, RETRIES);
        check("fail_ready", REQ_READY, 1);
        check("fail_pllrst", PLL_RST, 1);
        check("fail_gate", GATEO, 5'h1F);
        check("fail_locked", LOCKED, 0);
        check("fail_divs", cur_d, exp_d);
        PLL_LOCK = 1'b1;
        repeat (10) tick();
        check("fail_hold", FAIL, 1);

        // Leave FAIL through a new request.
        rd = {6'd7, 6'd14, 6'd3, 6'd3, 6'd3, 6'd3};
        send_req(rd);
        exp_d = rd;
        check("fail_exit", FAIL, 0);
        check("fail_exit_retry", RETRY_CNT, 0);
        check("fail_exit_divs", cur_d, exp_d);
        wait_locked("fail_exit_relock");

        // RST during WAIT_LOCK with a request pending.
        rd = {6'd11, 6'd22, 6'd5, 6'd6, 6'd7, 6'd8};
        send_req(rd);
        PLL_LOCK = 1'b0;
        measure_pwd(n);
        measure_rst(n);
        repeat (5) tick();
        check("pre_rst_divs", cur_d, rd);
        req_d = {6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3};
        REQ_VALID = 1'b1;
        RST = 1'b1;
        tick();
        check_reset_vals("midrst");
        RST = 1'b0;
        REQ_VALID = 1'b0;
        measure_rst(n);
        check("post_rst_len", n, RST_C);
        raise_and_time("post_rst_lock");
        check("post_rst_divs", cur_d, DEF_D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
